stream_data_router: RTL

- Sits directly downstream of the handshake-to-pulse reader stage.
- Consumes the single-cycle byte pulses from the reader and routes each byte to one of two places:
  - key bytes are assembled into a key register for the cipher core;
  - plaintext bytes are buffered in a small first-word-fall-through FIFO, drained by the cipher core over a valid/ready handshake.
- Flags protocol errors (plaintext with no valid key, FIFO overflow) in sticky bits readable by the FSM/status logic.

---
 rtl/stream_data_router_if.sv | 31 +++
 rtl/stream_data_router.sv | 115 +++++++++++
 2 files changed

// File: rtl/stream_data_router_if.sv
// Byte-stream bundle shared by the reader stage, the data router and the cipher core.
// The router attaches through the slave modport; the upstream/downstream side uses master.
interface stream_data_router_if #(
    parameter int KEY_BYTES = 4
);
    logic [7:0]             input_byte_pulsed;
    logic                   is_key_pulsed;
    logic                   input_byte_pulse;
    logic [8*KEY_BYTES-1:0] key_out;
    logic                   key_valid;
    logic                   key_load_pulse;
    logic [7:0]             data_out;
    logic                   data_valid;
    logic                   data_ready;
    logic                   fifo_full;
    logic                   err_no_key;
    logic                   err_overflow;
    logic                   clear_err;

    modport master (
        output input_byte_pulsed, is_key_pulsed, input_byte_pulse, data_ready, clear_err,
        input  key_out, key_valid, key_load_pulse, data_out, data_valid, fifo_full,
               err_no_key, err_overflow
    );

    modport slave (
        input  input_byte_pulsed, is_key_pulsed, input_byte_pulse, data_ready, clear_err,
        output key_out, key_valid, key_load_pulse, data_out, data_valid, fifo_full,
               err_no_key, err_overflow
    );
endinterface

// File: rtl/stream_data_router.sv
// Routes reader byte pulses: key bytes shift into the key register, plaintext bytes
// queue in a first-word-fall-through FIFO; protocol errors latch in sticky flags.
module stream_data_router #(
    parameter int KEY_BYTES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 nrst,
    stream_data_router_if.slave bus
);
    localparam int KW    = 8 * KEY_BYTES;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(KEY_BYTES);

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BYTES - 1);
    localparam logic [PTR_W:0]   DEPTH_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [KW-1:0]    key_q, key_d;
    logic [CNT_W-1:0] kcnt_q, kcnt_d;
    logic             key_valid_q, key_valid_d;
    logic             key_load_q, key_load_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             err_no_key_q, err_no_key_d;
    logic             err_overflow_q, err_overflow_d;

    logic key_byte, plain_byte, full, pop, push;

    assign key_byte   = bus.input_byte_pulse &  bus.is_key_pulsed;
    assign plain_byte = bus.input_byte_pulse & ~bus.is_key_pulsed;
    assign full       = (count_q == DEPTH_FULL);
    assign pop        = (count_q != '0) & bus.data_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = plain_byte & key_valid_q & (~full | pop);

    always_comb begin
        key_d       = key_q;
        kcnt_d      = kcnt_q;
        key_valid_d = key_valid_q;
        key_load_d  = 1'b0;
        if (key_byte) begin
            key_d = {key_q[KW-9:0], bus.input_byte_pulsed};
            if (key_valid_q) begin
                key_valid_d = 1'b0;
                kcnt_d      = CNT_W'(1);
            end else if (kcnt_q == KEY_LAST) begin
                kcnt_d      = '0;
                key_valid_d = 1'b1;
                key_load_d  = 1'b1;
            end else begin
                kcnt_d = kcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A new error event in the clearing cycle still sets the flag.
    always_comb begin
        err_no_key_d   = (bus.clear_err ? 1'b0 : err_no_key_q)   | (plain_byte & ~key_valid_q);
        err_overflow_d = (bus.clear_err ? 1'b0 : err_overflow_q) | (plain_byte & key_valid_q & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            key_q          <= '0;
            kcnt_q         <= '0;
            key_valid_q    <= 1'b0;
            key_load_q     <= 1'b0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            err_no_key_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            key_q          <= key_d;
            kcnt_q         <= kcnt_d;
            key_valid_q    <= key_valid_d;
            key_load_q     <= key_load_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            err_no_key_q   <= err_no_key_d;
            err_overflow_q <= err_overflow_d;
            if (push) begin
                mem_q[wr_ptr_q] <= bus.input_byte_pulsed;
            end
        end
    end

    assign bus.key_out        = key_q;
    assign bus.key_valid      = key_valid_q;
    assign bus.key_load_pulse = key_load_q;
    assign bus.data_out       = mem_q[rd_ptr_q];
    assign bus.data_valid     = (count_q != '0);
    assign bus.fifo_full      = full;
    assign bus.err_no_key     = err_no_key_q;
    assign bus.err_overflow   = err_overflow_q;
endmodule
